// File: rtl/bcd_counter_mod.sv
// Two-digit BCD modulo-N counter with up/down counting, validated parallel load,
// wrap or saturate at the terminal value, and a carry/borrow output for cascading.
module bcd_counter_mod #(
    parameter int MODULUS = 60,
    parameter bit WRAP    = 1'b1
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic       load,
    input  logic       en,
    input  logic       up,
    input  logic [3:0] d_lo,
    input  logic [3:0] d_hi,
    output logic [3:0] q_lo,
    output logic [3:0] q_hi,
    output logic       tc,
    output logic       co,
    output logic       load_err
);

    localparam int         MAX    = MODULUS - 1;
    localparam logic [3:0] MAX_HI = 4'(MAX / 10);
    localparam logic [3:0] MAX_LO = 4'(MAX % 10);

    logic [3:0] q_lo_q, q_lo_d;
    logic [3:0] q_hi_q, q_hi_d;
    logic       load_err_q, load_err_d;
    logic       at_max, at_zero, load_ok;

    always_comb begin
        at_max  = (q_hi_q == MAX_HI) && (q_lo_q == MAX_LO);
        at_zero = (q_hi_q == 4'd0) && (q_lo_q == 4'd0);
        // Digit-wise compare avoids building a binary value of the load word.
        load_ok = (d_lo <= 4'd9) && (d_hi <= 4'd9) &&
                  ((d_hi < MAX_HI) || ((d_hi == MAX_HI) && (d_lo <= MAX_LO)));
    end

    always_comb begin
        q_lo_d     = q_lo_q;
        q_hi_d     = q_hi_q;
        load_err_d = 1'b0;
        if (load) begin
            if (load_ok) begin
                q_lo_d = d_lo;
                q_hi_d = d_hi;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    if (WRAP) begin
                        q_lo_d = 4'd0;
                        q_hi_d = 4'd0;
                    end
                end else if (q_lo_q == 4'd9) begin
                    q_lo_d = 4'd0;
                    q_hi_d = q_hi_q + 4'd1;
                end else begin
                    q_lo_d = q_lo_q + 4'd1;
                end
            end else begin
                if (at_zero) begin
                    if (WRAP) begin
                        q_lo_d = MAX_LO;
                        q_hi_d = MAX_HI;
                    end
                end else if (q_lo_q == 4'd0) begin
                    q_lo_d = 4'd9;
                    q_hi_d = q_hi_q - 4'd1;
                end else begin
                    q_lo_d = q_lo_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            q_lo_q     <= 4'd0;
            q_hi_q     <= 4'd0;
            load_err_q <= 1'b0;
        end else begin
            q_lo_q     <= q_lo_d;
            q_hi_q     <= q_hi_d;
            load_err_q <= load_err_d;
        end
    end

    // co is combinational so a cascaded stage steps in the same cycle.
    assign tc       = up ? at_max : at_zero;
    assign co       = tc & en & ~load & clr_n;
    assign q_lo     = q_lo_q;
    assign q_hi     = q_hi_q;
    assign load_err = load_err_q;

endmodule

// File: doc/bcd_counter_mod.md
Name: bcd_counter_mod

Overview:
- Two-digit BCD modulo-N counter: generalised successor to the fixed mod-60 seconds/minutes stage.
- Adds modulus and mode parameters, up/down counting, validated parallel load, a wrap or saturate mode, and a carry/borrow output for cascading.
- One instance each serves seconds, minutes (MODULUS=60) and hours (MODULUS=24) in the clock datapath. The set/adjust logic can count down.

Parameters:
- MODULUS, 60, count range 0..MODULUS-1; legal 2..100.
- WRAP, 1, 1 = roll over at terminal; 0 = saturate (hold) at terminal.

Ports:
- clk  input  1  system clock, all state on rising edge
- clr_n  input  1  synchronous active-low reset
- load  input  1  parallel load request
- en  input  1  count enable (one step per cycle)
- up  input  1  direction: 1 = increment, 0 = decrement
- d_lo  input  4  load value, ones digit (BCD)
- d_hi  input  4  load value, tens digit (BCD)
- q_lo  output  4  count, ones digit (BCD)
- q_hi  output  4  count, tens digit (BCD)
- tc  output  1  terminal count (combinational)
- co  output  1  carry/borrow to next stage (combinational)
- load_err  output  1  rejected-load flag (registered, 1-cycle pulse)

Behaviour:
- Reset is synchronous and active-low: clr_n sampled low at a clk edge forces q_hi=0, q_lo=0 and load_err=0.
- Definitions: V = 10*q_hi + q_lo. MAX = MODULUS-1. MAX_HI = MAX/10. MAX_LO = MAX%10.
- Priority per cycle: reset > load > en > hold.
- Load accepted only if d_lo<=9, d_hi<=9 and 10*d_hi+d_lo <= MAX:
  - q_hi/q_lo take d_hi/d_lo on the next edge.
  - load_err=0.
- Load rejected otherwise:
  - q unchanged.
  - load_err=1 for exactly one cycle.
- Load has priority even when en=1: no count step occurs that cycle.
- Up count (en=1, up=1):
  - V==MAX: go to 00 if WRAP=1, hold if WRAP=0.
  - else q_lo==9: q_lo=0 and q_hi+1.
  - else q_lo+1.
- Down count (en=1, up=0):
  - V==0: go to MAX_HI:MAX_LO if WRAP=1, hold if WRAP=0.
  - else q_lo==0: q_lo=9 and q_hi-1.
  - else q_lo-1.
- Latency: one clk from qualified en/load to the new q.
- tc = (up & V==MAX) | (~up & V==0). tc is independent of en.
- co = tc & en & ~load & clr_n. Asserted in both WRAP modes. Intended to drive en of the next stage in the same cycle.
- Direction may change on any cycle. It takes effect for the step taken in that cycle.
- Out-of-range states are unreachable: reset and validated load are the only entry paths. No recovery logic is required.
- Reset mid-count or mid-load wins unconditionally. co is 0 during reset.
- All outputs are registered except tc and co.

Test Plan:
- MODULUS=60, WRAP=1, up=1, en=1 from reset: 00…09→10, 58→59 with tc=1 and co=1 during 59, →00 with co=0 next.
- MODULUS=24, WRAP=1, up=0, en=1 from 00: co=1 at 00, next=23, then 22, 21, 20, 19 (tens borrow at 20→19).
- MODULUS=60: load d_hi=7, d_lo=2 (72) → q unchanged, load_err=1 for one cycle. Load d_hi=1, d_lo=0xA → rejected, load_err pulse. Load 5,9 → q=59, load_err=0.
- MODULUS=100, WRAP=0: load 98, en=1 up=1 for 4 cycles → 99 and holds; co=1 every cycle at 99. up=0 at 00 → holds 00, co=1.
- Simultaneous load=1, en=1 at q=30 with d=45 → q=45 (no step). clr_n=0 with load=1, en=1 → q=00, load_err=0, co=0.
- Cascade: seconds (60) co drives minutes (60) en, minutes co ANDed into hours (24) en. Start at 23:59:59, en=1 → 00:00:00 in one clk.
